// File: rtl/ensamblador_paquetes.sv
// Packet assembler: gathers N_BYTES strobed data words into one wide packet and
// offers it downstream through a one-packet valid/ready buffer. The next packet
// keeps filling while the buffer waits for the consumer.
// Optional build macro ENSAMBLADOR_PARIDAD_EN adds per-word even-parity checking
// (input dato_par, output paquete_err).
module ensamblador_paquetes #(
  parameter int unsigned ANCHO_DATO = 8,
  parameter int unsigned N_BYTES    = 4,
  localparam int unsigned AC        = $clog2(N_BYTES)
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [ANCHO_DATO-1:0]         dato_in,
  input  logic                          dato_valido,
  output logic [ANCHO_DATO*N_BYTES-1:0] paquete_out,
  output logic                          paquete_valido,
  input  logic                          paquete_listo,
  output logic [AC-1:0]                 cuenta,
  output logic                          sobreflujo
`ifdef ENSAMBLADOR_PARIDAD_EN
  ,
  input  logic                          dato_par,
  output logic                          paquete_err
`endif
);

  // Words 0..N_BYTES-2 of the packet being filled; the last word goes straight
  // from dato_in into the output buffer.
  logic [N_BYTES-2:0][ANCHO_DATO-1:0] relleno_q;

  logic palabra_final;
  logic transferencia;

  assign palabra_final = dato_valido && (cuenta == AC'(N_BYTES - 1));
  // The buffer can take a new packet if empty or being drained on this edge.
  assign transferencia = palabra_final && (!paquete_valido || paquete_listo);

  // Fill index, fill slots, output buffer, handshake and sticky overflow.
  always_ff @(posedge clk) begin
    if (rst) begin
      relleno_q      <= '0;
      cuenta         <= '0;
      paquete_out    <= '0;
      paquete_valido <= 1'b0;
      sobreflujo     <= 1'b0;
    end else begin
      if (dato_valido && !palabra_final) begin
        relleno_q[cuenta] <= dato_in;
        cuenta            <= cuenta + AC'(1);
      end

      if (transferencia) begin
        paquete_out    <= {dato_in, relleno_q};
        paquete_valido <= 1'b1;
        cuenta         <= '0;
      end else if (paquete_valido && paquete_listo) begin
        paquete_valido <= 1'b0;
      end

      // Refused final word: dropped, cuenta stays at N_BYTES-1 so the next
      // strobe retries the completion.
      if (palabra_final && !transferencia) begin
        sobreflujo <= 1'b1;
      end
    end
  end

`ifdef ENSAMBLADOR_PARIDAD_EN
  logic err_acum_q;
  logic err_palabra;

  assign err_palabra = ^{dato_in, dato_par};

  // Parity error accumulator for the packet in progress; only accepted words count.
  always_ff @(posedge clk) begin
    if (rst) begin
      err_acum_q  <= 1'b0;
      paquete_err <= 1'b0;
    end else if (transferencia) begin
      paquete_err <= err_acum_q | err_palabra;
      err_acum_q  <= 1'b0;
    end else if (dato_valido && !palabra_final) begin
      err_acum_q <= err_acum_q | err_palabra;
    end
  end
`endif

endmodule

// File: tb/tb_ensamblador_paquetes.sv
// Self-checking bench for ensamblador_paquetes (default parameters).
module tb_ensamblador_paquetes;

  logic        clk = 1'b0;
  logic        rst;
  logic [7:0]  dato_in;
  logic        dato_valido;
  logic [31:0] paquete_out;
  logic        paquete_valido;
  logic        paquete_listo;
  logic [1:0]  cuenta;
  logic        sobreflujo;
`ifdef ENSAMBLADOR_PARIDAD_EN
  logic        dato_par;
  logic        paquete_err;
`endif

  ensamblador_paquetes #(
    .ANCHO_DATO(8),
    .N_BYTES   (4)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .dato_in       (dato_in),
    .dato_valido   (dato_valido),
    .paquete_out   (paquete_out),
    .paquete_valido(paquete_valido),
    .paquete_listo (paquete_listo),
    .cuenta        (cuenta),
    .sobreflujo    (sobreflujo)
`ifdef ENSAMBLADOR_PARIDAD_EN
    ,
    .dato_par      (dato_par),
    .paquete_err   (paquete_err)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        r;
    logic        v;
    logic [7:0]  d;
    logic        l;
    logic        nuevo;   // a new packet enters the buffer on this edge
    logic        e_pv;
    logic [31:0] e_po;
    logic [1:0]  e_c;
    logic        e_sf;
  } vec_t;

  vec_t        tabla[$];
  logic [31:0] sb[$];
  int          checks = 0;
  int          errors = 0;

  task automatic add(input logic r, input logic v, input logic [7:0] d, input logic l,
                     input logic nuevo, input logic pv, input logic [31:0] po,
                     input logic [1:0] c, input logic sf);
    vec_t x;
    x.r = r; x.v = v; x.d = d; x.l = l; x.nuevo = nuevo;
    x.e_pv = pv; x.e_po = po; x.e_c = c; x.e_sf = sf;
    tabla.push_back(x);
  endtask

  task automatic chk(input string nombre, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nombre, got, exp);
    end
  endtask

  // Drive one cycle; the scoreboard pops when the DUT hands a packet over on this edge.
  task automatic step(input logic r, input logic v, input logic [7:0] d, input logic l,
                      input logic bad);
    logic [31:0] esperado;
    rst = r; dato_valido = v; dato_in = d; paquete_listo = l;
`ifdef ENSAMBLADOR_PARIDAD_EN
    dato_par = (^d) ^ bad;
`endif
    @(negedge clk);
    if (!r && paquete_valido === 1'b1 && l) begin
      if (sb.size() == 0) begin
        chk("sb_vacio", 32'd1, 32'd0);
      end else begin
        esperado = sb.pop_front();
        chk("sb_paquete", paquete_out, esperado);
      end
    end
    @(posedge clk);
    #1;
    if (r) sb.delete();
  endtask

  initial begin
    rst = 1'b1; dato_valido = 1'b0; dato_in = '0; paquete_listo = 1'b0;
`ifdef ENSAMBLADOR_PARIDAD_EN
    dato_par = 1'b0;
`endif
    //   r  v  d      l  nuevo pv po            c  sf
    add(1, 0, 8'h00, 0, 0,    0, 32'h0,        0, 0);
    add(1, 0, 8'h00, 0, 0,    0, 32'h0,        0, 0);
    // Basic packet, listo high throughout
    add(0, 1, 8'h11, 1, 0,    0, 32'h0,        1, 0);
    add(0, 1, 8'h22, 1, 0,    0, 32'h0,        2, 0);
    add(0, 1, 8'h33, 1, 0,    0, 32'h0,        3, 0);
    add(0, 1, 8'h44, 1, 1,    1, 32'h44332211, 0, 0);
    add(0, 0, 8'h00, 1, 0,    0, 32'h44332211, 0, 0);
    // Consumer stalled: second packet waits, overflow on the next final word
    add(0, 1, 8'h44, 0, 0,    0, 32'h44332211, 1, 0);
    add(0, 1, 8'h33, 0, 0,    0, 32'h44332211, 2, 0);
    add(0, 1, 8'h22, 0, 0,    0, 32'h44332211, 3, 0);
    add(0, 1, 8'h11, 0, 1,    1, 32'h11223344, 0, 0);
    add(0, 1, 8'hA1, 0, 0,    1, 32'h11223344, 1, 0);
    add(0, 1, 8'hA2, 0, 0,    1, 32'h11223344, 2, 0);
    add(0, 1, 8'hA3, 0, 0,    1, 32'h11223344, 3, 0);
    add(0, 1, 8'hA4, 0, 0,    1, 32'h11223344, 3, 1);
    add(0, 0, 8'h00, 0, 0,    1, 32'h11223344, 3, 1);
    add(0, 1, 8'hA5, 1, 1,    1, 32'hA5A3A2A1, 0, 1);
    add(0, 0, 8'h00, 1, 0,    0, 32'hA5A3A2A1, 0, 1);
    // Same-cycle drain and refill: valid never drops
    add(0, 1, 8'hB1, 0, 0,    0, 32'hA5A3A2A1, 1, 1);
    add(0, 1, 8'hB2, 0, 0,    0, 32'hA5A3A2A1, 2, 1);
    add(0, 1, 8'hB3, 0, 0,    0, 32'hA5A3A2A1, 3, 1);
    add(0, 1, 8'hB4, 0, 1,    1, 32'hB4B3B2B1, 0, 1);
    add(0, 1, 8'hC1, 0, 0,    1, 32'hB4B3B2B1, 1, 1);
    add(0, 1, 8'hC2, 0, 0,    1, 32'hB4B3B2B1, 2, 1);
    add(0, 1, 8'hC3, 0, 0,    1, 32'hB4B3B2B1, 3, 1);
    add(0, 1, 8'hC4, 1, 1,    1, 32'hC4C3C2C1, 0, 1);
    add(0, 0, 8'h00, 0, 0,    1, 32'hC4C3C2C1, 0, 1);
    add(0, 0, 8'h00, 1, 0,    0, 32'hC4C3C2C1, 0, 1);
    // Reset mid-packet discards partial words
    add(0, 1, 8'hE1, 0, 0,    0, 32'hC4C3C2C1, 1, 1);
    add(0, 1, 8'hE2, 0, 0,    0, 32'hC4C3C2C1, 2, 1);
    add(1, 1, 8'hE3, 0, 0,    0, 32'h0,        0, 0);
    add(0, 1, 8'h01, 0, 0,    0, 32'h0,        1, 0);
    add(0, 1, 8'h02, 0, 0,    0, 32'h0,        2, 0);
    add(0, 1, 8'h03, 0, 0,    0, 32'h0,        3, 0);
    add(0, 1, 8'h04, 0, 1,    1, 32'h04030201, 0, 0);
    add(0, 0, 8'h00, 1, 0,    0, 32'h04030201, 0, 0);

    for (int i = 0; i < tabla.size(); i++) begin
      step(tabla[i].r, tabla[i].v, tabla[i].d, tabla[i].l, 1'b0);
      if (tabla[i].nuevo) sb.push_back(tabla[i].e_po);
      chk($sformatf("fila%0d paquete_valido", i), {31'd0, paquete_valido}, {31'd0, tabla[i].e_pv});
      chk($sformatf("fila%0d paquete_out", i), paquete_out, tabla[i].e_po);
      chk($sformatf("fila%0d cuenta", i), {30'd0, cuenta}, {30'd0, tabla[i].e_c});
      chk($sformatf("fila%0d sobreflujo", i), {31'd0, sobreflujo}, {31'd0, tabla[i].e_sf});
    end

`ifdef ENSAMBLADOR_PARIDAD_EN
    step(1'b1, 1'b0, 8'h00, 1'b0, 1'b0);
    chk("par_reset", {31'd0, paquete_err}, 32'd0);
    step(1'b0, 1'b1, 8'h10, 1'b0, 1'b0);
    step(1'b0, 1'b1, 8'h20, 1'b0, 1'b1);
    step(1'b0, 1'b1, 8'h30, 1'b0, 1'b0);
    step(1'b0, 1'b1, 8'h40, 1'b0, 1'b0);
    sb.push_back(32'h40302010);
    chk("par_malo_out", paquete_out, 32'h40302010);
    chk("par_malo_err", {31'd0, paquete_err}, 32'd1);
    step(1'b0, 1'b1, 8'h50, 1'b0, 1'b0);
    step(1'b0, 1'b1, 8'h60, 1'b0, 1'b0);
    step(1'b0, 1'b1, 8'h70, 1'b0, 1'b0);
    step(1'b0, 1'b1, 8'h80, 1'b1, 1'b0);
    sb.push_back(32'h80706050);
    chk("par_limpio_out", paquete_out, 32'h80706050);
    chk("par_limpio_err", {31'd0, paquete_err}, 32'd0);
    step(1'b0, 1'b0, 8'h00, 1'b1, 1'b0);
    chk("par_drenado", {31'd0, paquete_valido}, 32'd0);
`endif

    chk("sb_pendientes", sb.size(), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
